tristate_bus_arbiter: RTL

- Shares one tristate output driver among CHANNELS requesters.
- Round-robin arbitration; sequences each transfer as grant, then settle, then drive, then turnaround.
- Guarantees BusEnable is never high outside a granted drive window, and always leaves dead cycles between owners.
- BusData and BusEnable connect directly to the DataIn and OutputEnable inputs of the existing TriState buffer.

---
 rtl/tristate_bus_arbiter_pkg.sv | 21 ++
 rtl/tristate_bus_arbiter_rr_picker.sv | 34 +++
 rtl/tristate_bus_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
// Holds the transfer state encoding and the one-hot grant builder.
package tristate_bus_arbiter_pkg;

    localparam int MAX_CHANNELS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    function automatic logic [MAX_CHANNELS-1:0] onehot(input logic [2:0] index);
        logic [MAX_CHANNELS-1:0] vec;
        vec        = '0;
        vec[index] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// Round-robin picker: first requesting channel at or after the pointer,
// wrapping modulo CHANNELS. Purely combinational.
module tristate_bus_arbiter_rr_picker #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = 2
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [IDX_W-1:0]    pointer,
    output logic                valid,
    output logic [IDX_W-1:0]    index
);

    localparam logic [IDX_W:0] NCH = (IDX_W+1)'(CHANNELS);

    logic [IDX_W:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            cand = {1'b0, pointer} + (IDX_W+1)'(k);
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (request[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Shares one tristate driver among CHANNELS requesters: round-robin grant,
// one settle cycle, bounded drive window, then a forced turnaround gap.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 2,
    parameter int MAX_DRIVE  = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [CHANNELS-1:0]       Request,
    input  logic [CHANNELS*WIDTH-1:0] DataIn,
    output logic [CHANNELS-1:0]       Grant,
    output logic [WIDTH-1:0]          BusData,
    output logic                      BusEnable,
    output logic                      Busy,
    output logic                      Timeout
);

    localparam int IDX_W  = $clog2(CHANNELS);
    localparam int CNT_W  = (MAX_DRIVE > 0) ? $clog2(MAX_DRIVE + 1) : 1;
    localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_DRIVE);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
    localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(CHANNELS - 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  pointer;
    logic [IDX_W-1:0]  owner;
    logic [CNT_W-1:0]  drive_cnt;
    logic [TURN_W-1:0] turn_cnt;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_index;
    logic              owner_req;
    logic              drive_limit;

    tristate_bus_arbiter_rr_picker #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .request (Request),
        .pointer (pointer),
        .valid   (pick_valid),
        .index   (pick_index)
    );

    assign owner_req   = Request[owner];
    assign drive_limit = (MAX_DRIVE != 0) && (drive_cnt == CNT_LIMIT);
    assign Busy        = (state != IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            pointer   <= '0;
            owner     <= '0;
            drive_cnt <= '0;
            turn_cnt  <= '0;
            Grant     <= '0;
            BusEnable <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            Timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= SETUP;
                        owner   <= pick_index;
                        Grant   <= CHANNELS'(onehot(3'(pick_index)));
                        pointer <= (pick_index == LAST_CH) ? '0 : pick_index + IDX_W'(1);
                    end
                end
                SETUP: begin
                    if (owner_req) begin
                        state     <= DRIVE;
                        BusEnable <= 1'b1;
                        drive_cnt <= CNT_W'(1);
                    end else begin
                        state    <= TURN;
                        Grant    <= '0;
                        turn_cnt <= '0;
                    end
                end
                DRIVE: begin
                    // Owner still requesting here means the cut-off was the drive limit.
                    if (!owner_req || drive_limit) begin
                        state     <= TURN;
                        BusEnable <= 1'b0;
                        Grant     <= '0;
                        turn_cnt  <= '0;
                        Timeout   <= owner_req;
                    end else if (drive_cnt != '1) begin
                        drive_cnt <= drive_cnt + CNT_W'(1);
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + TURN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is one-hot or zero, so an OR of gated slices is a clean mux.
    always_comb begin
        BusData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (Grant[i]) begin
                BusData = BusData | DataIn[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule
